// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among N_REQ clients.
// Optional saturating result counters when CMP_STATS_EN is defined.
module comparator_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_flat,
  input  logic [N_REQ*WIDTH-1:0] b_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic                   less,
  output logic                   equal,
  output logic                   greater,
`ifdef CMP_STATS_EN
  output logic [7:0]             cnt_less,
  output logic [7:0]             cnt_equal,
  output logic [7:0]             cnt_greater,
`endif
  input  logic                   res_ack
);

  typedef enum logic [1:0] {IDLE, CMP, HOLD} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [ID_W-1:0] id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            found_c;
  logic [ID_W-1:0] win_c;
  logic [31:0]     idx_c;
  logic            lt_c, eq_c, gt_c;

  // Round-robin scan starting at ptr, wrapping modulo N_REQ
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_c = (32'(ptr) + k) % N_REQ;
      if (!found_c && req[ID_W'(idx_c)]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx_c);
      end
    end
  end

  assign ptr_nxt = (win_c == ID_W'(N_REQ - 1)) ? '0 : win_c + 1'b1;

  assign lt_c = (a_q < b_q);
  assign eq_c = (a_q == b_q);
  assign gt_c = (a_q > b_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found_c) state_nxt = CMP;
      CMP:     state_nxt = HOLD;
      HOLD:    if (res_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mealy grant, only while idle
  always_comb begin
    gnt = '0;
    if (state == IDLE && found_c) gnt[win_c] = 1'b1;
  end

  // Operand capture, compare result and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      less      <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found_c) begin
          a_q  <= a_flat[32'(win_c) * WIDTH +: WIDTH];
          b_q  <= b_flat[32'(win_c) * WIDTH +: WIDTH];
          id_q <= win_c;
          ptr  <= ptr_nxt;
        end
        CMP: begin
          less      <= lt_c;
          equal     <= eq_c;
          greater   <= gt_c;
          res_id    <= id_q;
          res_valid <= 1'b1;
        end
        HOLD: if (res_ack) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CMP_STATS_EN
  // Saturating per-outcome counters, bumped on every CMP->HOLD transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_less    <= '0;
      cnt_equal   <= '0;
      cnt_greater <= '0;
    end else if (state == CMP) begin
      if (lt_c && cnt_less    != 8'hFF) cnt_less    <= cnt_less + 8'd1;
      if (eq_c && cnt_equal   != 8'hFF) cnt_equal   <= cnt_equal + 8'd1;
      if (gt_c && cnt_greater != 8'hFF) cnt_greater <= cnt_greater + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed self-checking bench for comparator_arbiter (N_REQ=4, WIDTH=4).
module tb_comparator_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] a_flat, b_flat;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        less, equal, greater;
  logic        res_ack;
`ifdef CMP_STATS_EN
  logic [7:0]  cnt_less, cnt_equal, cnt_greater;
`endif

  int n_total = 0;
  int n_pass  = 0;

  comparator_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .res_valid(res_valid), .res_id(res_id),
    .less(less), .equal(equal), .greater(greater),
`ifdef CMP_STATS_EN
    .cnt_less(cnt_less), .cnt_equal(cnt_equal), .cnt_greater(cnt_greater),
`endif
    .res_ack(res_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    a_flat[i*4 +: 4] = a;
    b_flat[i*4 +: 4] = b;
  endtask

  // flags packed as {less, equal, greater}
  task automatic chk_res(input string tag, input logic [1:0] id, input logic [2:0] flags);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_id"}, 32'(res_id), 32'(id));
    check({tag, "_flags"}, 32'({less, equal, greater}), 32'(flags));
  endtask

  logic [2:0] rr_flags [4];

  initial begin
    rst_n = 1'b0; req = '0; res_ack = 1'b0; a_flat = '0; b_flat = '0;
    rr_flags[0] = 3'b010; rr_flags[1] = 3'b010; rr_flags[2] = 3'b100; rr_flags[3] = 3'b010;

    // 1. reset state
    repeat (2) mid();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_flags", 32'({less, equal, greater}), 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      mid();
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_valid", 32'(res_valid), 32'd0);
      cyc();
    end

    // 2. single requester
    set_ops(0, 4'b0001, 4'b0001); req = 4'b0001; res_ack = 1'b1;
    mid(); check("s1_gnt", 32'(gnt), 32'b0001);
    cyc(); req = '0;
    mid(); check("s1_cmp_valid", 32'(res_valid), 32'd0); check("s1_cmp_gnt", 32'(gnt), 32'd0);
    cyc();
    mid(); chk_res("s1", 2'd0, 3'b010);
    cyc();
    set_ops(0, 4'b0011, 4'b0001); req = 4'b0001;
    mid(); check("s2_ack_valid", 32'(res_valid), 32'd0); check("s2_gnt", 32'(gnt), 32'b0001);
    cyc(); req = '0;
    cyc();
    mid(); chk_res("s2", 2'd0, 3'b001);
    cyc();

    // 3. round-robin with all requesters active, pointer reset to 0 first
    rst_n = 1'b0;
    mid(); cyc();
    rst_n = 1'b1;
    set_ops(0, 4'b0101, 4'b0101); set_ops(1, 4'b1000, 4'b1000);
    set_ops(2, 4'b0110, 4'b1011); set_ops(3, 4'b1010, 4'b1010);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      mid(); check($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
      cyc();
      if (i == 4) req = '0;
      cyc();
      mid(); chk_res($sformatf("rr%0d", i), 2'(i % 4), rr_flags[i % 4]);
      cyc();
    end

    // 4. backpressure with requester 2 waiting (pointer now 1)
    res_ack = 1'b0; req = 4'b0010;
    mid(); check("bp_gnt1", 32'(gnt), 32'b0010);
    cyc(); req = 4'b0100;
    mid(); check("bp_cmp_gnt", 32'(gnt), 32'd0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      mid(); chk_res($sformatf("bp_hold%0d", i), 2'd1, 3'b010);
      check($sformatf("bp_hold%0d_gnt", i), 32'(gnt), 32'd0);
      cyc();
    end
    res_ack = 1'b1;
    mid(); chk_res("bp_ackcyc", 2'd1, 3'b010);
    cyc(); res_ack = 1'b0;
    mid(); check("bp_gnt2", 32'(gnt), 32'b0100); check("bp_rel_valid", 32'(res_valid), 32'd0);
    cyc(); req = '0;
    cyc();
    mid(); chk_res("bp_r2", 2'd2, 3'b100);
    res_ack = 1'b1;
    cyc();

    // 5. reset during CMP (pointer now 3)
    req = 4'b1000;
    mid(); check("mr_gnt", 32'(gnt), 32'b1000);
    cyc(); req = '0; rst_n = 1'b0;
    mid();
    check("mr_valid", 32'(res_valid), 32'd0);
    check("mr_flags", 32'({less, equal, greater}), 32'd0);
    check("mr_id", 32'(res_id), 32'd0);
    cyc();
    mid(); check("mr_valid2", 32'(res_valid), 32'd0);
    cyc(); rst_n = 1'b1; req = 4'b1010;
    mid(); check("mr_gnt_after", 32'(gnt), 32'b0010);
    cyc(); req = '0;
    cyc();
    mid(); chk_res("mr_r1", 2'd1, 3'b010);
    cyc();

`ifdef CMP_STATS_EN
    // 6. counter saturation
    rst_n = 1'b0;
    mid();
    check("st_rst_less", 32'(cnt_less), 32'd0);
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 4'd1, 4'd2);
    req = 4'b1111; res_ack = 1'b1;
    repeat (900) cyc();
    req = '0;
    repeat (4) cyc();
    mid();
    check("st_less", 32'(cnt_less), 32'd255);
    check("st_equal", 32'(cnt_equal), 32'd0);
    check("st_greater", 32'(cnt_greater), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
